// File: rtl/ifmap_free_ctrl.sv
// Ifmap buffer free controller: aggregates per-channel completes into bank
// free requests, queues them and hands them out round-robin over a valid/ready port.
module ifmap_free_ctrl #(
  parameter  int NUM_CH    = 4,
  parameter  int CNT_W     = 5,
  parameter  int NUM_BANKS = 4,
  parameter  int PEND_MAX  = 3,
  parameter  int L1_EVERY  = 2,
  parameter  int L2_EVERY  = 4,
  parameter  int L3_EVERY  = 1,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int PEND_W    = $clog2(PEND_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        layer_type,
  input  logic [CNT_W-1:0]  total_frees,
  input  logic [NUM_CH-1:0] complete,
  input  logic              free_ready,
  output logic              free_valid,
  output logic [BANK_W-1:0] free_bank,
  output logic              busy,
  output logic              layer_done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    agg_q, agg_d;
  logic [CNT_W-1:0]    gen_q, gen_d;
  logic [CNT_W-1:0]    done_q, done_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    every_q, every_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [BANK_W-1:0]   bank_d;
  logic                err_d;
  logic                ldone_d;

  logic                active;
  logic                hs;
  logic [NUM_CH-1:0]   mask_or;
  logic                dup;
  logic                evt;
  logic                exhausted;
  logic                at_every;
  logic                gen;

  // Event decode: complete is only observed while a layer runs and no start is present.
  always_comb begin
    active    = (state_q != S_IDLE) && !start;
    hs        = free_valid && free_ready;
    mask_or   = mask_q | complete;
    dup       = active && (|(mask_q & complete));
    evt       = active && (&mask_or);
    exhausted = (gen_q == total_q);
    at_every  = (agg_q == (every_q - CNT_W'(1)));
    gen       = evt && !exhausted && at_every;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    agg_d   = agg_q;
    gen_d   = gen_q;
    done_d  = done_q;
    total_d = total_q;
    every_d = every_q;
    pend_d  = pend_q;
    bank_d  = free_bank;
    err_d   = err;
    ldone_d = 1'b0;

    if (start) begin
      // Start (from any state) aborts and relatches; the bank pointer carries over.
      state_d = S_RUN;
      mask_d  = '0;
      agg_d   = '0;
      gen_d   = '0;
      done_d  = '0;
      pend_d  = '0;
      total_d = (total_frees == '0) ? CNT_W'(1) : total_frees;
      case (layer_type)
        2'd0:    every_d = CNT_W'(L1_EVERY);
        2'd1:    every_d = CNT_W'(L2_EVERY);
        2'd2:    every_d = CNT_W'(L3_EVERY);
        default: every_d = CNT_W'(1);
      endcase
      err_d = (layer_type == 2'd3);
    end else begin
      if (state_q != S_IDLE) begin
        mask_d = evt ? '0 : mask_or;
        if (dup) err_d = 1'b1;
        if (evt) begin
          if (exhausted)     err_d = 1'b1;
          else if (at_every) agg_d = '0;
          else               agg_d = agg_q + CNT_W'(1);
        end
      end

      if (gen) gen_d = gen_q + CNT_W'(1);

      if (hs) begin
        done_d = done_q + CNT_W'(1);
        bank_d = free_bank + BANK_W'(1);
      end

      case ({gen, hs})
        2'b10: begin
          if (pend_q == PEND_W'(PEND_MAX)) err_d  = 1'b1;
          else                             pend_d = pend_q + PEND_W'(1);
        end
        2'b01:   pend_d = pend_q - PEND_W'(1);
        default: pend_d = pend_q;
      endcase

      case (state_q)
        S_RUN: begin
          if (gen && (gen_d == total_q)) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (hs && (done_d == total_q)) begin
            state_d = S_IDLE;
            ldone_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      agg_q      <= '0;
      gen_q      <= '0;
      done_q     <= '0;
      total_q    <= '0;
      every_q    <= '0;
      pend_q     <= '0;
      free_bank  <= '0;
      free_valid <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      agg_q      <= agg_d;
      gen_q      <= gen_d;
      done_q     <= done_d;
      total_q    <= total_d;
      every_q    <= every_d;
      pend_q     <= pend_d;
      free_bank  <= bank_d;
      free_valid <= (pend_d != '0);
      busy       <= (state_d != S_IDLE);
      layer_done <= ldone_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_ifmap_free_ctrl.sv
// Bench for ifmap_free_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against an arithmetic reference model of the free-control rules.
module tb_ifmap_free_ctrl;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 5;
  localparam int NUM_BANKS = 4;
  localparam int PEND_MAX  = 3;
  localparam int L1_EVERY  = 2;
  localparam int L2_EVERY  = 4;
  localparam int L3_EVERY  = 1;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        layer_type;
  logic [CNT_W-1:0]  total_frees;
  logic [NUM_CH-1:0] complete;
  logic              free_ready;
  logic              free_valid;
  logic [BANK_W-1:0] free_bank;
  logic              busy;
  logic              layer_done;
  logic              err;

  always #5 clk = ~clk;

  ifmap_free_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .NUM_BANKS(NUM_BANKS), .PEND_MAX(PEND_MAX),
    .L1_EVERY(L1_EVERY), .L2_EVERY(L2_EVERY), .L3_EVERY(L3_EVERY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .layer_type(layer_type),
    .total_frees(total_frees), .complete(complete), .free_ready(free_ready),
    .free_valid(free_valid), .free_bank(free_bank), .busy(busy),
    .layer_done(layer_done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle 1=running 2=draining.
  int          m_phase, m_agg, m_gen, m_pend, m_done, m_bank, m_total, m_every;
  bit          m_seen [NUM_CH];
  bit          m_err, m_ldone;

  int          hs_banks [$];
  int          ldone_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit hs, fire, made;
    int n;
    if (rst) begin
      m_phase = 0; m_agg = 0; m_gen = 0; m_pend = 0; m_done = 0; m_bank = 0;
      m_total = 0; m_every = 0; m_err = 0; m_ldone = 0;
      foreach (m_seen[c]) m_seen[c] = 0;
    end else if (start) begin
      m_phase = 1; m_agg = 0; m_gen = 0; m_pend = 0; m_done = 0; m_ldone = 0;
      foreach (m_seen[c]) m_seen[c] = 0;
      m_total = (total_frees == 0) ? 1 : int'(total_frees);
      m_every = (layer_type == 0) ? L1_EVERY : (layer_type == 1) ? L2_EVERY :
                (layer_type == 2) ? L3_EVERY : 1;
      m_err   = (layer_type == 3);
    end else begin
      hs = (m_pend > 0) && free_ready;
      m_ldone = 0;
      fire = 0;
      made = 0;
      if (m_phase != 0) begin
        n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (complete[c]) begin
            if (m_seen[c]) m_err = 1;
            m_seen[c] = 1;
          end
          if (m_seen[c]) n++;
        end
        if (n == NUM_CH) begin
          fire = 1;
          foreach (m_seen[c]) m_seen[c] = 0;
        end
      end
      if (fire) begin
        if (m_gen == m_total) m_err = 1;
        else begin
          m_agg++;
          if (m_agg == m_every) begin m_agg = 0; made = 1; m_gen++; end
        end
      end
      if (hs) begin m_pend--; m_done++; m_bank = (m_bank + 1) % NUM_BANKS; end
      if (made) begin
        if (m_pend == PEND_MAX) m_err = 1;
        else m_pend++;
        if (m_phase == 1 && m_gen == m_total) m_phase = 2;
      end
      if (hs && m_phase == 2 && m_done == m_total) begin m_phase = 0; m_ldone = 1; end
    end
  endtask

  // One clock: update model with current inputs, clock DUT, compare, clear pulses.
  task automatic cycle();
    model_update();
    if (free_valid === 1'b1 && free_ready) hs_banks.push_back(int'(free_bank));
    @(posedge clk);
    #1;
    if (layer_done === 1'b1) ldone_cnt++;
    chk("free_valid", free_valid, (m_pend != 0));
    chk("free_bank",  free_bank,  m_bank);
    chk("busy",       busy,       (m_phase != 0));
    chk("layer_done", layer_done, m_ldone);
    chk("err",        err,        m_err);
    rst = 0; start = 0; complete = '0;
  endtask

  task automatic ev();
    complete = '1;
    cycle();
    cycle();
  endtask

  task automatic begin_layer(input int lt, input int tf, input bit rdy);
    rst = 1; cycle();
    layer_type = 2'(lt); total_frees = CNT_W'(tf); free_ready = rdy;
    start = 1; cycle();
    hs_banks.delete();
    ldone_cnt = 0;
  endtask

  initial begin
    rst = 1; start = 0; layer_type = '0; total_frees = '0; complete = '0; free_ready = 0;
    cycle();
    chk("reset_valid", free_valid, 0);
    chk("reset_busy",  busy,       0);
    chk("reset_err",   err,        0);

    // LAYER1, two frees, ready high
    begin_layer(0, 2, 1);
    repeat (4) ev();
    repeat (3) cycle();
    chk("l1_hs_count", hs_banks.size(), 2);
    chk("l1_bank0", (hs_banks.size() > 0) ? hs_banks[0] : -1, 0);
    chk("l1_bank1", (hs_banks.size() > 1) ? hs_banks[1] : -1, 1);
    chk("l1_ldone_cnt", ldone_cnt, 1);
    chk("l1_idle", busy, 0);

    // LAYER3 with ready low: pend saturates, 4th free dropped
    begin_layer(2, 8, 0);
    repeat (3) ev();
    chk("sat_err_before", err, 0);
    ev();
    chk("sat_err_after", err, 1);
    free_ready = 1;
    repeat (6) cycle();
    chk("sat_hs_count", hs_banks.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("sat_bank", (hs_banks.size() > i) ? hs_banks[i] : -1, i);
    chk("sat_drained", free_valid, 0);

    // Staggered channel completes with a repeated ch0 pulse
    begin_layer(2, 8, 1);
    for (int i = 0; i < 12; i++) begin
      complete = (i == 0 || i == 4) ? 4'b0001 : (i == 3) ? 4'b0010 :
                 (i == 5) ? 4'b0100 : (i == 9) ? 4'b1000 : 4'b0000;
      cycle();
      if (i == 4) chk("stag_dup_err", err, 1);
      if (i == 8) chk("stag_no_early", hs_banks.size() + int'(free_valid), 0);
      if (i == 9) chk("stag_event", free_valid, 1);
    end
    chk("stag_one_free", hs_banks.size(), 1);

    // LAYER2 simultaneous generate and handshake with pend=1
    begin_layer(1, 8, 0);
    repeat (7) ev();
    free_ready = 1; complete = '1; cycle();
    chk("sim_valid", free_valid, 1);
    chk("sim_bank", free_bank, 1);
    free_ready = 0; cycle();
    chk("sim_pend_kept", free_valid, 1);

    // Abort during DRAIN with two frees queued
    begin_layer(2, 2, 0);
    ev(); ev();
    chk("abort_pre_busy", busy, 1);
    layer_type = 2'd0; total_frees = CNT_W'(3); start = 1; cycle();
    chk("abort_valid", free_valid, 0);
    chk("abort_err", err, 0);
    chk("abort_busy", busy, 1);
    ev(); ev();
    chk("abort_run_gen", free_valid, 1);
    chk("abort_run_err", err, 0);
    free_ready = 1; repeat (3) cycle();
    chk("abort_no_ldone", ldone_cnt, 0);

    // Reset mid-layer with a free pending, then completes in IDLE are ignored
    begin_layer(2, 4, 0);
    ev();
    chk("rst_pre_valid", free_valid, 1);
    rst = 1; cycle();
    chk("rst_valid", free_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bank", free_bank, 0);
    ev();
    chk("idle_ignore", free_valid, 0);

    // Reserved layer type and total_frees of zero
    begin_layer(3, 2, 0);
    chk("rsv_err", err, 1);
    ev();
    chk("rsv_every1", free_valid, 1);
    begin_layer(2, 0, 1);
    ev();
    chk("zero_ldone", ldone_cnt, 1);
    chk("zero_idle", busy, 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 59) == 0);
      layer_type = 2'($urandom_range(0, 3));
      total_frees = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0) complete = ($urandom_range(0, 3) == 0) ? '1 : '0;
      else for (int c = 0; c < NUM_CH; c++) complete[c] = ($urandom_range(0, 3) == 0);
      free_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmap_free_ctrl.md
IFMAP_FREE_CTRL -- requirements
Module: ifmap_free_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of PE channels reporting complete.
REQ-002 SHALL have parameter CNT_W, default 5: width of all event counters.
REQ-003 SHALL have parameter NUM_BANKS, default 4: ifmap buffer banks, freed round-robin; power of two, at least 2.
REQ-004 SHALL have parameter PEND_MAX, default 3: maximum queued un-acknowledged frees.
REQ-005 SHALL have parameters L1_EVERY=2, L2_EVERY=4, L3_EVERY=1: aggregate completes per free for LAYER1/2/3.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins a layer.
REQ-009 SHALL have port layer_type, input, 2: LAYER1=0, LAYER2=1, LAYER3=2, 3=reserved; sampled only on start.
REQ-010 SHALL have port total_frees, input, CNT_W: number of frees in the layer; sampled on start; 0 is treated as 1.
REQ-011 SHALL have port complete, input, NUM_CH: per-channel single-cycle completion pulses.
REQ-012 SHALL have port free_ready, input, 1: buffer accepts the current free.
REQ-013 SHALL have port free_valid, output, 1: a free request is pending.
REQ-014 SHALL have port free_bank, output, clog2(NUM_BANKS): bank to free; stable while free_valid=1 and free_ready=0.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.
REQ-016 SHALL have port layer_done, output, 1: one-cycle pulse after the last free is accepted.
REQ-017 SHALL have port err, output, 1: sticky error flag, cleared only by start or rst.

Function
REQ-018 SHALL keep a per-channel sticky mask; a complete bit sets its mask bit; an aggregate event fires in the cycle the mask becomes all-ones, counting that cycle's pulses; the mask clears in the same edge.
REQ-019 SHALL OR a complete pulse that arrives on an already-set mask bit into the mask, count nothing, and set err.
REQ-020 SHALL count aggregate events in agg_cnt; when agg_cnt reaches EVERY-1 and an event fires, SHALL clear agg_cnt and generate one free; EVERY is chosen by the latched layer_type.
REQ-021 SHALL, for reserved layer_type, use EVERY=1 and set err.
REQ-022 SHALL queue generated frees in a pend counter (0..PEND_MAX); free_valid = (pend != 0).
REQ-023 SHALL treat a handshake (free_valid & free_ready) as decrementing pend, advancing free_bank modulo NUM_BANKS, and incrementing done_cnt.
REQ-024 SHALL, on simultaneous generate and handshake, leave pend unchanged.
REQ-025 SHALL, on generate with pend=PEND_MAX and no handshake, drop that free, keep pend saturated, and set err.
REQ-026 SHALL stop generating frees once generated frees equal total_frees; further aggregate events set err.
REQ-027 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-028 SHALL transition IDLE->RUN on start.
REQ-029 SHALL transition RUN->DRAIN when the final free is generated.
REQ-030 SHALL transition DRAIN->IDLE on the handshake that makes done_cnt equal total_frees, and pulse layer_done in the following cycle.
REQ-031 SHALL, on start in RUN or DRAIN, abort the layer: clear mask, agg_cnt, pend, done_cnt, and err, relatch the configuration, remain in RUN, leave free_bank unchanged, and suppress layer_done.
REQ-032 SHALL ignore complete in IDLE.
REQ-033 SHALL, when start and complete occur in the same cycle, ignore complete.
REQ-034 SHALL register every output; the latency from the generating complete to free_valid is 1 cycle.
REQ-035 SHALL wrap all counters modulo 2^CNT_W; total_frees never exceeds 2^CNT_W-1.

Reset
REQ-036 SHALL, with rst=1 at a clock edge, enter IDLE and clear mask, agg_cnt, pend, done_cnt, free_bank, free_valid, busy, layer_done, and err to 0.
REQ-037 SHALL give rst priority over start and all other inputs; rst mid-layer discards queued frees without handshake.

Verification
REQ-038 SHALL pass: LAYER1, total_frees=2, NUM_CH=4, four aggregate events with free_ready=1 -> free_valid pulses after events 2 and 4, free_bank 0 then 1, layer_done 1 cycle after the second handshake, busy=0 thereafter.
REQ-039 SHALL pass: LAYER3, free_ready=0, four events -> pend saturates at 3, err=1 on the 4th; then free_ready=1 -> exactly 3 handshakes, banks 0,1,2.
REQ-040 SHALL pass: channels complete on staggered cycles 0,3,5,9 -> exactly one event at cycle 9; a repeat ch0 pulse at cycle 4 -> err=1, no extra event.
REQ-041 SHALL pass: LAYER2 generate and handshake in the same cycle with pend=1 -> pend stays 1, free_bank increments by 1.
REQ-042 SHALL pass: start during DRAIN with pend=2 -> pend=0, err=0, state RUN, no layer_done pulse.
REQ-043 SHALL pass: rst asserted for 1 cycle in RUN with free_valid=1 -> next cycle all outputs 0 and state IDLE.
